operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  Issue stage directly upstream of the ALU. Decodes a 12-bit instruction, reads two
//  operands from an internal 8x12 register file and registers the packed 27-bit ALU
//  word {opcode, opA, opB}. A per-register scoreboard stalls issue on RAW/WAW hazards
//  until the ALU result returns through the writeback port.
// PARAMETERS
//  NREG  8   register count (address width = clog2(NREG) = 3)
//  DW    12  register / operand width
//  OPW   3   opcode width; ALU word width = OPW + 2*DW = 27
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   instruction present
//  in_ready   out  1   stage accepts instruction this cycle
//  instr      in   12  [11:9] opcode, [8:6] rd, [5:3] rsa, [2:0] rsb
//  out_valid  out  1   alu_x/out_rd valid
//  out_ready  in   1   downstream ALU/writeback path accepts
//  alu_x      out  27  [26:24] opcode, [23:12] rf[rsa], [11:0] rf[rsb]
//  out_rd     out  3   destination tag travelling with alu_x
//  wb_en      in   1   writeback strobe
//  wb_addr    in   3   writeback register
//  wb_data    in   12  writeback value (ALU Y)
//  busy       out  NREG scoreboard pending bits (debug)
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, alu_x=0, out_rd=0, busy=0, all regs=0.
//   Reset mid-transfer drops the held word; no partial state survives.
//  hazard = pend[rsa] | pend[rsb] | pend[rd]  (WAW included; one bit per reg).
//  in_ready = (!out_valid | out_ready) & !hazard. Combinational; independent of in_valid.
//  Accept = in_valid & in_ready. On accept, next edge: out_valid=1, alu_x/out_rd load,
//   pend[rd] set. Latency instr->alu_x = 1 cycle; throughput 1/cycle with no hazards.
//  Hold: out_valid & !out_ready -> alu_x, out_rd stable; in_ready=0.
//  Drain: out_ready & !accept -> out_valid clears next edge.
//  Writeback: wb_en -> rf[wb_addr]<=wb_data, pend[wb_addr] cleared, same edge.
//  Same-edge set and clear of one pend bit: set wins (new accept owns register).
//  Operand read without FORWARD_EN: rf read pre-edge; hazard uses registered pend only,
//   so a source retiring this cycle still stalls one more cycle.
//  wb_en to a non-pending register: legal; rf written, pend unchanged (stays 0).
//  Widths: operands zero-extension-free, exact DW bits; no arithmetic performed here.
//  Scoreboard state: per reg IDLE(pend=0) -> PENDING on accept with rd -> IDLE on wb.
// CONFIGURATION
//  FORWARD_EN defined: hazard uses pend & ~(wb_en one-hot wb_addr); a source equal
//   to wb_addr with wb_en reads wb_data instead of rf (bypass), issuing same cycle.
//  FORWARD_EN undefined: no bypass; behaviour exactly as BEHAVIOUR above
//   (one extra stall cycle per dependent instruction).
// TESTING
//  1 Reset: rst_n low mid-hold with out_valid=1 -> out_valid=0, busy=0, alu_x=0 async.
//  2 wb r1=0x00A, r2=0x005; issue op=3'b001 rd=3 rsa=1 rsb=2 -> next cycle
//    alu_x=27'h100A005, out_rd=3, busy[3]=1.
//  3 Back-pressure: out_ready=0 for 4 cycles -> alu_x stable, in_ready=0; release ->
//    next instr issued following cycle, none lost/duplicated.
//  4 RAW: issue rd=3, then rsa=3 -> in_ready=0 until wb r3=0xFFF; without FORWARD_EN
//    issues cycle after wb with opA=0xFFF; with FORWARD_EN issues same cycle as wb.
//  5 WAW + same-edge: issue rd=4 pending; wb r4 and accept rd=4 same edge
//    (FORWARD_EN) -> busy[4]=1 after edge.
//  6 Stream 16 independent instrs, out_ready=1 -> 16 words, 1/cycle, order preserved.

Source files
------------

// File: rtl/operand_fetch_stage_if.sv
// Instruction, ALU-word and writeback bundle between the issue stage and its neighbours.
// slave is the stage side; master is the decoder/ALU side that drives the stage.
interface operand_fetch_stage_if #(
    parameter int NREG = 8,
    parameter int DW   = 12,
    parameter int OPW  = 3
);
    localparam int AW = $clog2(NREG);
    localparam int IW = OPW + 3 * AW;
    localparam int XW = OPW + 2 * DW;

    logic            in_valid;
    logic            in_ready;
    logic [IW-1:0]   instr;
    logic            out_valid;
    logic            out_ready;
    logic [XW-1:0]   alu_x;
    logic [AW-1:0]   out_rd;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic [NREG-1:0] busy;

    modport master (
        output in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, alu_x, out_rd, busy
    );

    modport slave (
        input  in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, alu_x, out_rd, busy
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Issue stage ahead of the ALU: decode, register-file read, scoreboarded issue of {opcode, opA, opB}.
// Optional macro FORWARD_EN: same-cycle writeback bypasses both the operand read and the hazard check.
module operand_fetch_stage #(
    parameter int NREG = 8,
    parameter int DW   = 12,
    parameter int OPW  = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    operand_fetch_stage_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int XW = OPW + 2 * DW;

    typedef enum logic {
        SB_IDLE    = 1'b0,
        SB_PENDING = 1'b1
    } sb_state_e;

    logic [OPW-1:0]  w_op;
    logic [AW-1:0]   w_rd;
    logic [AW-1:0]   w_rsa;
    logic [AW-1:0]   w_rsb;
    logic [NREG-1:0] w_pend;
    logic [NREG-1:0] w_pend_eff;
    logic [NREG-1:0] w_wb_hot;
    logic [NREG-1:0] w_set_hot;
    logic            w_hazard;
    logic            w_ready;
    logic            w_accept;
    logic [DW-1:0]   w_opa;
    logic [DW-1:0]   w_opb;

    sb_state_e       r_sb [NREG];
    logic [DW-1:0]   r_rf [NREG];
    logic            r_out_valid;
    logic [XW-1:0]   r_alu_x;
    logic [AW-1:0]   r_out_rd;

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
        logic [NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Instruction field split.
    always_comb begin
        w_op  = bus.instr[OPW+3*AW-1 -: OPW];
        w_rd  = bus.instr[3*AW-1 -: AW];
        w_rsa = bus.instr[2*AW-1 -: AW];
        w_rsb = bus.instr[AW-1:0];
    end

    // Scoreboard view, hazard detection and issue handshake.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_pend[i] = (r_sb[i] == SB_PENDING);
        end
        if (bus.wb_en) begin
            w_wb_hot = onehot(bus.wb_addr);
        end else begin
            w_wb_hot = '0;
        end
`ifdef FORWARD_EN
        // A source retiring this cycle is released early; its value comes off the bypass.
        w_pend_eff = w_pend & ~w_wb_hot;
`else
        w_pend_eff = w_pend;
`endif
        w_hazard = w_pend_eff[w_rsa] | w_pend_eff[w_rsb] | w_pend_eff[w_rd];
        w_ready  = (~r_out_valid | bus.out_ready) & ~w_hazard;
        w_accept = bus.in_valid & w_ready;
        if (w_accept) begin
            w_set_hot = onehot(w_rd);
        end else begin
            w_set_hot = '0;
        end
    end

    // Operand read, optionally bypassing the writeback port.
    always_comb begin
`ifdef FORWARD_EN
        if (bus.wb_en && (bus.wb_addr == w_rsa)) begin
            w_opa = bus.wb_data;
        end else begin
            w_opa = r_rf[w_rsa];
        end
        if (bus.wb_en && (bus.wb_addr == w_rsb)) begin
            w_opb = bus.wb_data;
        end else begin
            w_opb = r_rf[w_rsb];
        end
`else
        w_opa = r_rf[w_rsa];
        w_opb = r_rf[w_rsb];
`endif
    end

    // Register file, written only from the writeback port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (bus.wb_en) begin
            r_rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Per-register scoreboard; a new accept owns the register even if it retires on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_sb[i] <= SB_IDLE;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                case (r_sb[i])
                    SB_IDLE: begin
                        if (w_set_hot[i]) begin
                            r_sb[i] <= SB_PENDING;
                        end else begin
                            r_sb[i] <= SB_IDLE;
                        end
                    end
                    SB_PENDING: begin
                        if (w_set_hot[i]) begin
                            r_sb[i] <= SB_PENDING;
                        end else if (w_wb_hot[i]) begin
                            r_sb[i] <= SB_IDLE;
                        end else begin
                            r_sb[i] <= SB_PENDING;
                        end
                    end
                    default: begin
                        r_sb[i] <= SB_IDLE;
                    end
                endcase
            end
        end
    end

    // Output word register: load on accept, hold under back-pressure, drop valid once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_x     <= '0;
            r_out_rd    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_alu_x     <= {w_op, w_opa, w_opb};
            r_out_rd    <= w_rd;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.alu_x     = r_alu_x;
    assign bus.out_rd    = r_out_rd;
    assign bus.busy      = w_pend;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed scenarios then random traffic against a
// register-file/pending-set reference model; honours FORWARD_EN the same way the design does.
module tb_operand_fetch_stage;
    localparam int NREG = 8;
    localparam int DW   = 12;
    localparam int OPW  = 3;
`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [26:0] x;
        logic [2:0]  rd;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_stage_if #(.NREG(NREG), .DW(DW), .OPW(OPW)) bus ();

    operand_fetch_stage #(.NREG(NREG), .DW(DW), .OPW(OPW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [DW-1:0] m_rf [NREG];
    logic [7:0]    m_pend;
    bit            m_ov;
    exp_t          sb_q [$];
    int            n_vec  = 0;
    int            n_fail = 0;
    int            n_pop  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rsa, input logic [2:0] rsb);
        return {op, rd, rsa, rsb};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        m_pend = '0;
        m_ov   = 1'b0;
        sb_q.delete();
    endtask

    function automatic logic [DW-1:0] m_read(input logic [2:0] rs, input bit wen,
                                            input logic [2:0] wa, input logic [DW-1:0] wd);
        if (FWD && wen && wa == rs) return wd;
        return m_rf[rs];
    endfunction

    function automatic bit m_hazard(input logic [11:0] ins, input bit wen, input logic [2:0] wa);
        logic [7:0] p;
        p = m_pend;
        if (FWD && wen) p[wa] = 1'b0;
        return p[ins[5:3]] | p[ins[2:0]] | p[ins[8:6]];
    endfunction

    // One clock of stimulus: drive, predict/check handshake at negedge, advance model at posedge.
    task automatic step(input bit iv, input logic [11:0] ins, input bit ordy, input bit wen,
                        input logic [2:0] wa, input logic [DW-1:0] wd, output bit acc);
        bit   exp_rdy;
        exp_t e;
        bus.in_valid  = iv;
        bus.instr     = ins;
        bus.out_ready = ordy;
        bus.wb_en     = wen;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        @(negedge clk);
        exp_rdy = (!m_ov || ordy) && !m_hazard(ins, wen, wa);
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        chk("busy", {24'd0, bus.busy}, {24'd0, m_pend});
        acc = iv && exp_rdy;
        e.x  = {ins[11:9], m_read(ins[5:3], wen, wa, wd), m_read(ins[2:0], wen, wa, wd)};
        e.rd = ins[8:6];
        @(posedge clk);
        if (acc) sb_q.push_back(e);
        if (wen) begin
            m_rf[wa]   = wd;
            m_pend[wa] = 1'b0;
        end
        if (acc) begin
            m_pend[ins[8:6]] = 1'b1;
            m_ov = 1'b1;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    // Monitor: every presented word must match the oldest expected entry; pop on handshake.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", {31'd0, bus.out_valid}, (sb_q.size() != 0) ? 32'd1 : 32'd0);
                if (bus.out_valid && sb_q.size() != 0) begin
                    chk("alu_x", {5'd0, bus.alu_x}, {5'd0, sb_q[0].x});
                    chk("out_rd", {29'd0, bus.out_rd}, {29'd0, sb_q[0].rd});
                    if (bus.out_ready) begin
                        void'(sb_q.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench still running at %0t, expected to finish", $time);
        $fatal(1);
    end

    initial begin : main
        bit acc;
        int k;
        int pops0;
        int cnt;
        logic [11:0] ins;
        m_reset();
        bus.in_valid = 1'b0; bus.instr = '0; bus.out_ready = 1'b0;
        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_alu_x", {5'd0, bus.alu_x}, 32'd0);
        chk("rst_out_rd", {29'd0, bus.out_rd}, 32'd0);
        chk("rst_busy", {24'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;

        // 1: asynchronous reset while a word is held
        step(1'b1, mk(3'b010, 3'd5, 3'd0, 3'd0), 1'b0, 1'b0, 3'd0, 12'h000, acc);
        step(1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 12'h000, acc);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_busy", {24'd0, bus.busy}, 32'd0);
        chk("async_rst_alu_x", {5'd0, bus.alu_x}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 2: basic issue
        step(1'b0, 12'h000, 1'b1, 1'b1, 3'd1, 12'h00A, acc);
        step(1'b0, 12'h000, 1'b1, 1'b1, 3'd2, 12'h005, acc);
        step(1'b1, mk(3'b001, 3'd3, 3'd1, 3'd2), 1'b0, 1'b0, 3'd0, 12'h000, acc);
        chk("t2_alu_x", {5'd0, bus.alu_x}, 32'h0100A005);
        chk("t2_out_rd", {29'd0, bus.out_rd}, 32'd3);
        chk("t2_busy3", {31'd0, bus.busy[3]}, 32'd1);

        // 3: back-pressure for four cycles, then release
        repeat (4) step(1'b1, mk(3'b011, 3'd5, 3'd1, 3'd2), 1'b0, 1'b0, 3'd0, 12'h000, acc);
        chk("t3_held_alu_x", {5'd0, bus.alu_x}, 32'h0100A005);
        step(1'b1, mk(3'b011, 3'd5, 3'd1, 3'd2), 1'b1, 1'b0, 3'd0, 12'h000, acc);
        chk("t3_release_accept", {31'd0, acc}, 32'd1);
        step(1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, acc);

        // 4: RAW on r3, retired with 0xFFF on the third attempt
        for (k = 0; k < 6; k++) begin
            step(1'b1, mk(3'b100, 3'd6, 3'd3, 3'd1), 1'b1, (k == 2), 3'd3, 12'hFFF, acc);
            if (acc) break;
        end
        chk("t4_raw_issue_cycle", k, FWD ? 32'd2 : 32'd3);
        chk("t4_raw_opA", {20'd0, bus.alu_x[23:12]}, 32'h00000FFF);
        step(1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, acc);

        // 5: WAW on r4 with writeback and re-issue racing
        step(1'b1, mk(3'b110, 3'd4, 3'd0, 3'd0), 1'b1, 1'b0, 3'd0, 12'h000, acc);
        for (k = 0; k < 6; k++) begin
            step(1'b1, mk(3'b111, 3'd4, 3'd0, 3'd0), 1'b1, (k == 1), 3'd4, 12'h123, acc);
            if (acc) break;
        end
        chk("t5_waw_issue_cycle", k, FWD ? 32'd1 : 32'd2);
        chk("t5_waw_busy4", {31'd0, bus.busy[4]}, 32'd1);
        step(1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, acc);

        // 6: sixteen independent instructions back to back
        for (int i = 0; i < NREG; i++)
            step(1'b0, 12'h000, 1'b1, 1'b1, 3'(i), 12'($urandom), acc);
        pops0 = n_pop;
        cnt   = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, mk(3'($urandom), 3'(i), 3'(i + 1), 3'(i + 2)), 1'b1, (i >= 4), 3'(i - 4),
                 12'($urandom), acc);
            if (acc) cnt++;
        end
        step(1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, acc);
        step(1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, acc);
        chk("t6_stream_accepts", cnt, 32'd16);
        chk("t6_stream_words", n_pop - pops0, 32'd16);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ins = 12'($urandom);
            step(($urandom_range(0, 9) < 7), ins, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 4), 3'($urandom), 12'($urandom), acc);
        end
        repeat (3) step(1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, acc);
        chk("final_queue_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
